// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types, including the branch history table entry encoding.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_t;

   localparam bht_state_t BHT_RESET_STATE = WNT;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] cnt, input logic en);
      return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
   endfunction

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Next-state logic for one 2-bit saturating branch counter.
module sat_counter2
   import rv32i_types::*;
(
   input  bht_state_t state,
   input  logic       br_en,
   output bht_state_t next_state
);

   always_comb begin
      next_state = state;
      case (state)
         SNT: next_state = br_en ? WNT : SNT;
         WNT: next_state = br_en ? WT  : SNT;
         WT:  next_state = br_en ? ST  : WNT;
         ST:  next_state = br_en ? ST  : WT;
         default: next_state = BHT_RESET_STATE;
      endcase
   end

endmodule

// File: rtl/branch_history_table.sv
// 2-bit counter branch predictor with misprediction flag and statistics.
// Define BHT_GSHARE_EN to XOR a global outcome history into the table index.
module branch_history_table
   import rv32i_types::*;
#(
   parameter int IDX_BITS  = 6,
   parameter int HIST_BITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         pred_pc,
   output logic                pred_taken,
   output logic [IDX_BITS-1:0] pred_idx,
   input  logic                upd_valid,
   input  logic [IDX_BITS-1:0] upd_idx,
   input  logic                upd_pred,
   input  logic                br_en,
   output logic                mispredict,
   output logic [31:0]         branch_cnt,
   output logic [31:0]         mispred_cnt
);

   localparam int NUM_ENTRIES = 2 ** IDX_BITS;

   // upd_valid is a one-cycle qualifier with no back-pressure: every cycle it
   // is high, upd_idx/upd_pred/br_en describe exactly one resolved branch.
   bht_state_t        table_q [NUM_ENTRIES];
   bht_state_t        upd_cur;
   bht_state_t        upd_next;
   logic              upd_wrong;
   logic [31:0]       branch_cnt_q;
   logic [31:0]       mispred_cnt_q;
   logic              mispredict_q;
   logic              unused_pc;

   assign unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

`ifdef BHT_GSHARE_EN
   logic [HIST_BITS-1:0] ghr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr <= '0;
      end else if (upd_valid) begin
         ghr <= {ghr[HIST_BITS-2:0], br_en};
      end
   end

   // History occupies the low index bits; zero-extension covers HIST_BITS < IDX_BITS.
   assign pred_idx = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
`else
   localparam int unused_hist_bits = HIST_BITS;

   assign pred_idx = pred_pc[IDX_BITS+1:2];
`endif

   // Reads see the table before any same-cycle update lands.
   assign pred_taken = table_q[pred_idx][1];

   assign upd_cur   = table_q[upd_idx];
   assign upd_wrong = upd_valid && (br_en != upd_pred);

   sat_counter2 u_sat_counter2 (
      .state      (upd_cur),
      .br_en      (br_en),
      .next_state (upd_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            table_q[i] <= BHT_RESET_STATE;
         end
      end else if (upd_valid) begin
         table_q[upd_idx] <= upd_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
         mispredict_q  <= 1'b0;
      end else begin
         branch_cnt_q  <= sat_inc32(branch_cnt_q, upd_valid);
         mispred_cnt_q <= sat_inc32(mispred_cnt_q, upd_wrong);
         mispredict_q  <= upd_wrong;
      end
   end

   assign mispredict  = mispredict_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table (default build; gshare path when BHT_GSHARE_EN is defined).
module tb_branch_history_table;

   logic        clk;
   logic        rst;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [5:0]  pred_idx;
   logic        upd_valid;
   logic [5:0]  upd_idx;
   logic        upd_pred;
   logic        br_en;
   logic        mispredict;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int n_cmp = 0;
   int n_err = 0;

   branch_history_table #(.IDX_BITS(6), .HIST_BITS(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .pred_pc     (pred_pc),
      .pred_taken  (pred_taken),
      .pred_idx    (pred_idx),
      .upd_valid   (upd_valid),
      .upd_idx     (upd_idx),
      .upd_pred    (upd_pred),
      .br_en       (br_en),
      .mispredict  (mispredict),
      .branch_cnt  (branch_cnt),
      .mispred_cnt (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; presents one update across the next rising edge.
   task automatic upd_cycle(input logic [5:0] idx, input logic pred, input logic br);
      upd_valid = 1'b1;
      upd_idx   = idx;
      upd_pred  = pred;
      br_en     = br;
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; upd_valid = 1'b0; upd_idx = '0; upd_pred = 1'b0; br_en = 1'b0;
      pred_pc = 32'h0000_0040;
      @(negedge clk);
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
      n_cmp++; if (pred_idx !== 6'd16) begin n_err++; $display("FAIL reset_pred_idx: got %0d expected 16", pred_idx); end
      n_cmp++; if (branch_cnt !== 32'd0) begin n_err++; $display("FAIL reset_branch_cnt: got %0h expected 0", branch_cnt); end
      n_cmp++; if (mispred_cnt !== 32'd0) begin n_err++; $display("FAIL reset_mispred_cnt: got %0h expected 0", mispred_cnt); end
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_train_taken();
      pred_pc = 32'h0000_0040;
      upd_cycle(6'd16, 1'b0, 1'b1);
      n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL train1_mispredict: got %b expected 1", mispredict); end
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train1_pred_taken: got %b expected 1", pred_taken); end
      upd_cycle(6'd16, 1'b1, 1'b1);
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL train2_mispredict: got %b expected 0", mispredict); end
      upd_cycle(6'd16, 1'b1, 1'b1);
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL train3_mispredict: got %b expected 0", mispredict); end
      n_cmp++; if (branch_cnt !== 32'd3) begin n_err++; $display("FAIL train_branch_cnt: got %0d expected 3", branch_cnt); end
      n_cmp++; if (mispred_cnt !== 32'd1) begin n_err++; $display("FAIL train_mispred_cnt: got %0d expected 1", mispred_cnt); end
   endtask

   // Entry 16 is ST: one not-taken keeps it predicting taken, the second flips it.
   task automatic test_back_to_back_decrement();
      pred_pc = 32'h0000_0040;
      upd_cycle(6'd16, 1'b1, 1'b0);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL dec1_pred_taken: got %b expected 1", pred_taken); end
      n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL dec1_mispredict: got %b expected 1", mispredict); end
      upd_cycle(6'd16, 1'b1, 1'b0);
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL dec2_pred_taken: got %b expected 0", pred_taken); end
      n_cmp++; if (mispred_cnt !== 32'd3) begin n_err++; $display("FAIL dec_mispred_cnt: got %0d expected 3", mispred_cnt); end
   endtask

   task automatic test_same_cycle();
      pred_pc = 32'h0000_0014;
      upd_cycle(6'd5, 1'b0, 1'b1);
      upd_valid = 1'b1; upd_idx = 6'd5; upd_pred = 1'b1; br_en = 1'b0;
      #1;
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL same_cycle_pre: got %b expected 1", pred_taken); end
      @(negedge clk);
      upd_valid = 1'b0;
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL same_cycle_post: got %b expected 0", pred_taken); end
      n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL same_cycle_mispredict: got %b expected 1", mispredict); end
      n_cmp++; if (branch_cnt !== 32'd7) begin n_err++; $display("FAIL same_cycle_branch_cnt: got %0d expected 7", branch_cnt); end
   endtask

   task automatic test_snt_saturation();
      pred_pc = 32'h0000_001C;
      upd_cycle(6'd7, 1'b0, 1'b0);
      upd_cycle(6'd7, 1'b0, 1'b0);
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL snt_mispredict: got %b expected 0", mispredict); end
      upd_cycle(6'd7, 1'b0, 1'b1);
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL snt_up1_pred_taken: got %b expected 0", pred_taken); end
      upd_cycle(6'd7, 1'b0, 1'b1);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL snt_up2_pred_taken: got %b expected 1", pred_taken); end
      n_cmp++; if (branch_cnt !== 32'd11) begin n_err++; $display("FAIL snt_branch_cnt: got %0d expected 11", branch_cnt); end
      n_cmp++; if (mispred_cnt !== 32'd7) begin n_err++; $display("FAIL snt_mispred_cnt: got %0d expected 7", mispred_cnt); end
   endtask

   task automatic test_idle();
      pred_pc = 32'h0000_001C;
      upd_valid = 1'b0; upd_idx = 6'd7; upd_pred = 1'b1; br_en = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL idle_pred_taken: got %b expected 1", pred_taken); end
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL idle_mispredict: got %b expected 0", mispredict); end
      n_cmp++; if (branch_cnt !== 32'd11) begin n_err++; $display("FAIL idle_branch_cnt: got %0d expected 11", branch_cnt); end
      n_cmp++; if (mispred_cnt !== 32'd7) begin n_err++; $display("FAIL idle_mispred_cnt: got %0d expected 7", mispred_cnt); end
   endtask

   task automatic test_cnt_saturation();
      force dut.branch_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.branch_cnt_q;
      #1;
      n_cmp++; if (branch_cnt !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload: got %0h expected fffffffe", branch_cnt); end
      @(negedge clk);
      upd_cycle(6'd9, 1'b0, 1'b0);
      n_cmp++; if (branch_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_first: got %0h expected ffffffff", branch_cnt); end
      upd_cycle(6'd9, 1'b0, 1'b0);
      upd_cycle(6'd9, 1'b0, 1'b0);
      n_cmp++; if (branch_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold: got %0h expected ffffffff", branch_cnt); end
      n_cmp++; if (mispred_cnt !== 32'd7) begin n_err++; $display("FAIL sat_mispred_cnt: got %0d expected 7", mispred_cnt); end
   endtask

   task automatic test_reset_mid_update();
      pred_pc = 32'h0000_001C;
      upd_cycle(6'd7, 1'b0, 1'b1);
      upd_valid = 1'b1; upd_idx = 6'd20; upd_pred = 1'b1; br_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL mid_rst_mispredict: got %b expected 0", mispredict); end
      n_cmp++; if (branch_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_branch_cnt: got %0h expected 0", branch_cnt); end
      n_cmp++; if (mispred_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_mispred_cnt: got %0h expected 0", mispred_cnt); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL mid_rst_pred_taken: got %b expected 0", pred_taken); end
      @(negedge clk);
      upd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      pred_pc = 32'h0000_0050;
      upd_cycle(6'd20, 1'b0, 1'b1);
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL mid_rst_entry_wnt: got %b expected 1", pred_taken); end
      n_cmp++; if (branch_cnt !== 32'd1) begin n_err++; $display("FAIL mid_rst_post_cnt: got %0d expected 1", branch_cnt); end
   endtask

`ifdef BHT_GSHARE_EN
   task automatic test_gshare();
      upd_cycle(6'd0, 1'b0, 1'b1);
      upd_cycle(6'd0, 1'b0, 1'b0);
      upd_cycle(6'd0, 1'b0, 1'b1);
      pred_pc = 32'h0000_0000;
      #1;
      n_cmp++; if (pred_idx !== 6'd5) begin n_err++; $display("FAIL gshare_idx_pc0: got %0d expected 5", pred_idx); end
      pred_pc = 32'h0000_0040;
      #1;
      n_cmp++; if (pred_idx !== 6'd21) begin n_err++; $display("FAIL gshare_idx_pc40: got %0d expected 21", pred_idx); end
      n_cmp++; if (branch_cnt !== 32'd3) begin n_err++; $display("FAIL gshare_branch_cnt: got %0d expected 3", branch_cnt); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef BHT_GSHARE_EN
      test_gshare();
`else
      test_train_taken();
      test_back_to_back_decrement();
      test_same_cycle();
      test_snt_saturation();
      test_idle();
      test_cnt_saturation();
      test_reset_mid_update();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch predictor consuming the resolved branch outcome (`br_en`) produced by the branch comparator in execute. Fetch queries it with the current PC and gets a taken/not-taken prediction plus a table index. The index travels down the pipeline and returns with the resolved outcome one or more cycles later. The block trains a table of 2-bit saturating counters, flags mispredictions, and keeps branch and misprediction statistics.

## Interface
- `IDX_BITS`, 6: table index width; table has 2^IDX_BITS entries.
- `HIST_BITS`, 6: global history length; must be ≤ IDX_BITS. Used only with `BHT_GSHARE_EN`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pred_pc`  in  32  fetch PC (`rv32i_word`).
- `pred_taken`  out  1  combinational prediction for `pred_pc`.
- `pred_idx`  out  IDX_BITS  index used for the prediction; carried down the pipeline.
- `upd_valid`  in  1  a conditional branch resolved this cycle.
- `upd_idx`  in  IDX_BITS  `pred_idx` that was captured at fetch for this branch.
- `upd_pred`  in  1  `pred_taken` that was captured at fetch for this branch.
- `br_en`  in  1  actual outcome from the comparator.
- `mispredict`  out  1  registered pulse: previous-cycle update had `br_en != upd_pred`.
- `branch_cnt`  out  32  resolved-branch count.
- `mispred_cnt`  out  32  mispredicted-branch count.

## Operation
- Entry encoding is `bht_state_t`: SNT=00, WNT=01, WT=10, ST=11. Prediction is bit [1] of the entry.
- Base index: `pred_idx = pred_pc[IDX_BITS+1:2]`.
- Update, when `upd_valid` is high:
  - `br_en`=1 increments `table[upd_idx]`, saturating at ST.
  - `br_en`=0 decrements `table[upd_idx]`, saturating at SNT.
- `upd_valid` low: no table, counter, or history change.
- Read is combinational from current table contents. A predict and an update to the same index in one cycle return the pre-update value. The write takes effect at the edge.
- `mispredict` is set for exactly one cycle after an update with `br_en != upd_pred`; otherwise 0.
- `branch_cnt` increments on every update. `mispred_cnt` increments on every mispredicting update.
- Both counters saturate at 32'hFFFF_FFFF and never wrap.
- `upd_idx` is trusted and is not range-checked; all IDX_BITS values are legal.

## Timing
- Prediction latency 0 cycles, combinational from `pred_pc` and table state.
- Update latency 1 cycle: table, counters, and `mispredict` reflect an update after the next rising edge.
- One update per cycle maximum. Back-to-back updates to the same index accumulate: two taken updates move WNT→WT→ST.
- Reset, asynchronous assert:
  - all entries become WNT
  - `mispredict`=0
  - `branch_cnt`=0
  - `mispred_cnt`=0
  - history = 0
- Reset asserted mid-update discards that update.
- During reset `pred_taken`=0 for every PC.

## Configuration
- `BHT_GSHARE_EN` defined:
  - A HIST_BITS global history register `ghr` is added.
  - `pred_idx = pred_pc[IDX_BITS+1:2] ^ {{(IDX_BITS-HIST_BITS){1'b0}}, ghr}`.
  - On each update, `ghr <= {ghr[HIST_BITS-2:0], br_en}`. History is non-speculative and updated at resolution only.
- Undefined: no history register; index is PC bits only; HIST_BITS is ignored.

## Structure
- Add to `rv32i_types`: `bht_state_t` enum (SNT, WNT, WT, ST) and constant `BHT_RESET_STATE = WNT`.
- Sub-module `sat_counter2`: takes a state and `br_en`, returns the next state. It is combinational and instantiated once on the update path.
- Table is a flop array with async reset; no SRAM macro is used.

## Test plan
- Reset, then query `pred_pc`=32'h0000_0040 → `pred_taken`=0, `pred_idx`=16, both counters 0.
- Three taken updates on idx 16 with `upd_pred`=0,1,1 → entry WNT→WT→ST→ST. `mispredict` pulses only after the first update. `branch_cnt`=3, `mispred_cnt`=1.
- Same-cycle predict and update on idx 5, entry WT, `br_en`=0 → `pred_taken`=1 that cycle and 0 the next.
- Preload `branch_cnt` near saturation (force to 32'hFFFF_FFFE), issue 3 updates → holds at 32'hFFFF_FFFF.
- Assert `rst` low mid-cycle while `upd_valid`=1 → outputs clear immediately and the entry remains WNT after release.
- With `BHT_GSHARE_EN`: outcomes 1,0,1 give `ghr`=6'b000101; `pred_pc`=32'h0 → `pred_idx`=5.
